serial_receiver_5bit: RTL and testbench
=======================================

// Module: serial_receiver_5bit
// PURPOSE
//  Receive end of the 5-bit circular right-shift link. The transmitter shifts
//  right, so bit0 goes out first (LSB-first). This block deserializes that
//  stream into a 5-bit word.
//  - Frame alignment: a bit counter aligned by frameStart.
//  - Output: a holding register with a valid/ack handshake.
//  - Sits between the serial line and the downstream display/consumer logic.
// PARAMETERS
//  WIDTH        5  word length in bits (frame = WIDTH valid bits)
//  COUNT_WIDTH  3  bit-counter width; must satisfy 2**COUNT_WIDTH > WIDTH
// PORTS
//  clockpulse   in   1      single clock; all state changes on its rising edge
//  clear        in   1      reset, asynchronous, active-low; clears all state
//  serialIn     in   1      serial data bit, LSB first
//  serialValid  in   1      serialIn is sampled on an edge only while high
//  frameStart   in   1      qualified by serialValid; marks the current bit as bit0
//  wordAck      in   1      consumer has taken wordOut
//  wordOut      out  WIDTH  last complete received word
//  notWordOut   out  WIDTH  bitwise complement of wordOut
//  wordValid    out  1      wordOut holds an unacknowledged word
//  bitCount     out  COUNT_WIDTH  bits received in the current frame (0..WIDTH-1)
//  overrun      out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (clear=0, async):
//   - shift reg=0, wordOut=0, notWordOut=all 1s, wordValid=0
//   - bitCount=0, overrun=0, state=IDLE
//  Sample: a bit is accepted on a rising edge only when serialValid=1.
//  Shift rule on each accepted bit: shift right; serialIn enters bit WIDTH-1.
//  After WIDTH accepted bits, the first bit is at bit0.
//  FSM (2 states):
//   - IDLE: bits ignored unless frameStart=1.
//     Accepted frameStart bit -> shift, bitCount=1, go to RECV.
//   - RECV, accepted bit, frameStart=0: shift, bitCount+1.
//   - RECV, accepted bit, frameStart=1: resync. Partial frame is discarded;
//     the bit is treated as bit0 and bitCount=1. No flag is raised.
//   - RECV, bit number WIDTH accepted (bitCount was WIDTH-1): frame complete.
//     bitCount returns to 0 and state returns to IDLE.
//   - serialValid=0: state, counter and shift reg hold.
//  Completion, same edge as the last bit (latency 0 cycles after that edge):
//   - wordValid=0, or wordAck=1 this edge: load the word (including the last bit)
//     into wordOut; wordValid=1.
//   - wordValid=1 and wordAck=0: keep the old wordOut; drop the new word;
//     set overrun=1.
//  Handshake:
//   - wordAck with wordValid=1 and no completion: wordValid=0 on that edge.
//     wordOut keeps its value.
//   - wordAck with wordValid=0: ignored.
//  overrun is cleared only by clear.
//  notWordOut is always ~wordOut, combinational from the register.
//  Reset mid-frame: the partial frame is lost; the next frame needs frameStart.
// STRUCTURE
//  Shared package/header:
//   - WIDTH default
//   - state encodings IDLE=1'b0, RECV=1'b1
//   - COUNT_WIDTH
//  Sub-module shift_register_5bit_sipo:
//   - serial-in/parallel-out right shifter with shift enable
//   - async active-low clear
//   - built from flipflopJk cells: J=d, K=~d
//   - parameterised by WIDTH
//  Top level holds the FSM, bitCount, holding register, handshake and overrun.
// TESTING
//  1. Reset: clear=0 mid-stream -> all outputs at reset values immediately,
//     with no clock edge.
//  2. Basic frame: frameStart on bit0, send 0,1,1,0,1 with serialValid=1
//     -> wordOut=5'b10110, notWordOut=5'b01001, wordValid=1 on the 5th edge.
//  3. Gaps: same frame with serialValid=0 for 3 cycles between bits 2 and 3
//     -> identical result; bitCount holds at 2 during the gap.
//  4. Resync: 3 bits, then frameStart with 1,1,1,1,1 -> wordOut=5'b11111,
//     overrun=0.
//  5. Overrun: complete 5'b00011, no ack, complete 5'b11100
//     -> wordOut stays 5'b00011, overrun=1.
//     A later clear -> overrun=0.
//  6. Simultaneous: wordAck on the same edge a new word 5'b01010 completes
//     -> wordOut=5'b01010, wordValid stays 1, overrun=0.
//     Idle bits without frameStart -> bitCount stays 0.

Source files
------------

// File: rtl/serial_receiver_5bit_pkg.sv
// Shared definitions for the 5-bit serial receive link: word/counter widths
// and the frame-alignment state encoding.
package serial_receiver_5bit_pkg;

   localparam int WIDTH_DEF       = 5;
   localparam int COUNT_WIDTH_DEF = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } rx_state_t;

endpackage

// File: rtl/serial_receiver_5bit_sipo.sv
// Serial-in/parallel-out right shifter built from JK flip-flop cells.
// Holds when shift_en is low (J=K=0); loads d when high (J=d, K=~d).
module flipflop_jk (
   input  logic clk,
   input  logic clear_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

module shift_register_5bit_sipo #(
   parameter int WIDTH = serial_receiver_5bit_pkg::WIDTH_DEF
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] d;

   // Right shift: new bit enters the MSB, so after WIDTH shifts the first bit sits at bit0.
   assign d = {serial_in, q[WIDTH-1:1]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      flipflop_jk u_ff (
         .clk     (clk),
         .clear_n (clear_n),
         .j       (shift_en & d[i]),
         .k       (shift_en & ~d[i]),
         .q       (q[i])
      );
   end

endmodule

// File: rtl/serial_receiver_5bit.sv
// Receive end of the 5-bit LSB-first link: frame alignment FSM, bit counter,
// holding register with valid/ack handshake and sticky overrun flag.
//
//  state | meaning
//  IDLE  | waiting for an accepted bit with frameStart (bit0 of a frame)
//  RECV  | collecting bits 1..WIDTH-1 of the current frame
module serial_receiver_5bit
   import serial_receiver_5bit_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   clockpulse,
   input  logic                   clear,
   input  logic                   serialIn,
   input  logic                   serialValid,
   input  logic                   frameStart,
   input  logic                   wordAck,
   output logic [WIDTH-1:0]       wordOut,
   output logic [WIDTH-1:0]       notWordOut,
   output logic                   wordValid,
   output logic [COUNT_WIDTH-1:0] bitCount,
   output logic                   overrun
);

   localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(WIDTH - 1);
   localparam logic [COUNT_WIDTH-1:0] FIRST_CNT = COUNT_WIDTH'(1);

   rx_state_t              state, state_next;
   logic [COUNT_WIDTH-1:0] count_next;
   logic                   shift_en;
   logic                   frame_done;
   logic [WIDTH-1:0]       shift_q;
   logic [WIDTH-1:0]       word_new;

   shift_register_5bit_sipo #(.WIDTH(WIDTH)) u_sipo (
      .clk       (clockpulse),
      .clear_n   (clear),
      .shift_en  (shift_en),
      .serial_in (serialIn),
      .q         (shift_q)
   );

   // The completed word includes the bit being shifted in on this edge.
   assign word_new = {serialIn, shift_q[WIDTH-1:1]};

   always_ff @(posedge clockpulse or negedge clear) begin
      if (!clear) begin
         state    <= IDLE;
         bitCount <= '0;
      end else begin
         state    <= state_next;
         bitCount <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = bitCount;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      if (serialValid) begin
         case (state)
            IDLE: begin
               if (frameStart) begin
                  shift_en   = 1'b1;
                  count_next = FIRST_CNT;
                  state_next = RECV;
               end
            end
            RECV: begin
               shift_en = 1'b1;
               if (frameStart) begin
                  count_next = FIRST_CNT;
               end else if (bitCount == LAST_BIT) begin
                  frame_done = 1'b1;
                  count_next = '0;
                  state_next = IDLE;
               end else begin
                  count_next = bitCount + FIRST_CNT;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // A completion with an ack on the same edge hands over the new word directly.
   always_ff @(posedge clockpulse or negedge clear) begin
      if (!clear) begin
         wordOut   <= '0;
         wordValid <= 1'b0;
         overrun   <= 1'b0;
      end else if (frame_done) begin
         if (!wordValid || wordAck) begin
            wordOut   <= word_new;
            wordValid <= 1'b1;
         end else begin
            overrun   <= 1'b1;
         end
      end else if (wordAck) begin
         wordValid <= 1'b0;
      end
   end

   assign notWordOut = ~wordOut;

endmodule

// File: tb/tb_serial_receiver_5bit.sv
// Directed plus randomized bench for serial_receiver_5bit against a
// frame-list reference model.
module tb_serial_receiver_5bit;

   logic       clockpulse = 1'b0;
   logic       clear = 1'b0;
   logic       serialIn = 1'b0;
   logic       serialValid = 1'b0;
   logic       frameStart = 1'b0;
   logic       wordAck = 1'b0;
   logic [4:0] wordOut, notWordOut;
   logic       wordValid;
   logic [2:0] bitCount;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   // reference model: bits of the frame in progress, listed by arrival order
   int         m_len = 0;
   logic [4:0] m_bits = '0;
   logic [4:0] m_word = '0;
   logic       m_valid = 1'b0;
   logic       m_ovr = 1'b0;

   serial_receiver_5bit dut (
      .clockpulse  (clockpulse),
      .clear       (clear),
      .serialIn    (serialIn),
      .serialValid (serialValid),
      .frameStart  (frameStart),
      .wordAck     (wordAck),
      .wordOut     (wordOut),
      .notWordOut  (notWordOut),
      .wordValid   (wordValid),
      .bitCount    (bitCount),
      .overrun     (overrun)
   );

   always #5 clockpulse = ~clockpulse;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".wordOut"},    {3'b0, wordOut},    {3'b0, m_word});
      chk({tag, ".notWordOut"}, {3'b0, notWordOut}, {3'b0, ~m_word});
      chk({tag, ".wordValid"},  {7'b0, wordValid},  {7'b0, m_valid});
      chk({tag, ".bitCount"},   {5'b0, bitCount},   8'(m_len));
      chk({tag, ".overrun"},    {7'b0, overrun},    {7'b0, m_ovr});
   endtask

   task automatic model_reset();
      m_len = 0; m_bits = '0; m_word = '0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_edge(input logic sv, input logic fs, input logic b, input logic ack);
      logic done;
      logic [4:0] w;
      done = 1'b0;
      w = '0;
      if (sv) begin
         if (fs) begin
            m_bits = '0; m_bits[0] = b; m_len = 1;
         end else if (m_len > 0) begin
            m_bits[m_len] = b; m_len++;
         end
         if (m_len == 5) begin
            for (int i = 0; i < 5; i++) w = w + (5'(m_bits[i]) << i);
            done = 1'b1;
            m_len = 0;
         end
      end
      if (done) begin
         if (!m_valid || ack) begin
            m_word = w; m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (ack) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic step(input logic sv, input logic fs, input logic b, input logic ack,
                       input string tag);
      @(negedge clockpulse);
      serialValid = sv; frameStart = fs; serialIn = b; wordAck = ack;
      @(posedge clockpulse);
      model_edge(sv, fs, b, ack);
      #1;
      chk_model(tag);
   endtask

   task automatic send_word(input logic [4:0] w, input logic ack_last, input string tag);
      for (int i = 0; i < 5; i++)
         step(1'b1, i == 0, w[i], ack_last && i == 4, tag);
   endtask

   initial begin
      #12;
      chk_model("reset_init");
      clear = 1'b1;

      // 1. asynchronous reset mid-frame, checked without any clock edge
      step(1'b1, 1'b1, 1'b1, 1'b0, "t1_bit0");
      step(1'b1, 1'b0, 1'b1, 1'b0, "t1_bit1");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t1_bit2");
      @(negedge clockpulse);
      #2 clear = 1'b0;
      model_reset();
      #1;
      chk_model("t1_async_clear");
      chk("t1_bitCount0", {5'b0, bitCount}, 8'd0);
      @(negedge clockpulse);
      clear = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0, "t1_no_fs_after_clear");

      // 2. basic frame
      send_word(5'b10110, 1'b0, "t2");
      chk("t2_wordOut", {3'b0, wordOut}, 8'b10110);
      chk("t2_notWordOut", {3'b0, notWordOut}, 8'b01001);
      chk("t2_wordValid", {7'b0, wordValid}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, "t2_ack");
      chk("t2_ack_valid", {7'b0, wordValid}, 8'd0);
      chk("t2_ack_keep", {3'b0, wordOut}, 8'b10110);

      // 3. gaps in serialValid
      step(1'b1, 1'b1, 1'b0, 1'b0, "t3_b0");
      step(1'b1, 1'b0, 1'b1, 1'b0, "t3_b1");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, "t3_gap");
         chk("t3_gap_count", {5'b0, bitCount}, 8'd2);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, "t3_b2");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t3_b3");
      step(1'b1, 1'b0, 1'b1, 1'b0, "t3_b4");
      chk("t3_wordOut", {3'b0, wordOut}, 8'b10110);
      step(1'b0, 1'b0, 1'b0, 1'b1, "t3_ack");

      // 4. resync after a partial frame
      step(1'b1, 1'b1, 1'b0, 1'b0, "t4_p0");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t4_p1");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t4_p2");
      send_word(5'b11111, 1'b0, "t4");
      chk("t4_wordOut", {3'b0, wordOut}, 8'b11111);
      chk("t4_overrun", {7'b0, overrun}, 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, "t4_ack");

      // 5. overrun
      send_word(5'b00011, 1'b0, "t5_a");
      send_word(5'b11100, 1'b0, "t5_b");
      chk("t5_wordOut", {3'b0, wordOut}, 8'b00011);
      chk("t5_overrun", {7'b0, overrun}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, "t5_ack");
      chk("t5_sticky", {7'b0, overrun}, 8'd1);
      @(negedge clockpulse);
      clear = 1'b0;
      model_reset();
      #1;
      chk("t5_clear_ovr", {7'b0, overrun}, 8'd0);
      @(negedge clockpulse);
      clear = 1'b1;

      // 6. ack coincident with completion, then idle bits
      send_word(5'b00101, 1'b0, "t6_a");
      send_word(5'b01010, 1'b1, "t6_b");
      chk("t6_wordOut", {3'b0, wordOut}, 8'b01010);
      chk("t6_wordValid", {7'b0, wordValid}, 8'd1);
      chk("t6_overrun", {7'b0, overrun}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'(i), 1'b0, "t6_idle");
         chk("t6_idle_count", {5'b0, bitCount}, 8'd0);
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, ($urandom % 7) == 0, 1'($urandom),
              ($urandom % 4) == 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
